psync_sched: RTL and testbench
==============================

// Module: psync_sched
// PURPOSE
//  Single-clock scheduler that shares one psync pulse-synchronizer instance between N_CH event sources.
//  - Accumulates per-channel event pulses in saturating pending counters.
//  - Picks channels round-robin and issues at most one pulse per GAP cycles to the psync input.
//  - Holds the granted channel id stable so the destination domain can sample it after the synced pulse.
//  - Sits in the source clock domain, directly in front of the psync input.
// PARAMETERS
//  N_CH   4  number of requesting channels (2..16)
//  CNT_W  4  pending-counter width per channel; saturates at 2**CNT_W-1
//  GAP    4  minimum cycles between issued pulses (>=2); set for psync dest/src clock ratio
// PORTS
//  sys_clk    in   1              source-domain clock
//  sys_rst_n  in   1              asynchronous active-low reset
//  req        in   N_CH           per-channel event pulses, any combination per cycle
//  ovf_clr    in   1              clears all ovf bits (one-cycle strobe)
//  o          out  1              pulse to psync input, one cycle wide
//  o_ch       out  $clog2(N_CH)   channel of last issued pulse, stable until next issue
//  pending    out  N_CH           bit k = counter k nonzero
//  ovf        out  N_CH           sticky: request lost on channel k due to saturation
// BEHAVIOUR
//  Reset (async, sys_rst_n=0):
//  - Clears all counters; o=0, o_ch=0, pending=0, ovf=0, state IDLE.
//  - Round-robin pointer returns to 0, so channel 0 is searched first.
//  - A reset mid-HOLD or mid-ISSUE discards all pending counts.
//  Counters, per channel, registered:
//  - req only: +1. Grant only: -1. Both in the same cycle: unchanged.
//  - req at saturation with no grant: count held, ovf[k] set.
//  - ovf_clr clears ovf, but a same-cycle overflow wins and sets the bit.
//  FSM IDLE / ISSUE / HOLD:
//  - IDLE: if any counter nonzero, grant the first nonzero channel at or after ptr (wrapping).
//    Next cycle: ISSUE with o=1 and o_ch=grant; that counter decrements, ptr <= grant+1 mod N_CH.
//  - ISSUE: lasts 1 cycle, then HOLD; o=0 in all other states.
//  - HOLD: GAP-1 cycles, timed by a down-counter. At expiry:
//    - any pending -> grant and ISSUE directly, so pulse spacing is exactly GAP;
//    - otherwise -> IDLE.
//  Latency and throughput:
//  - req asserted in cycle t with empty counters: o=1 in cycle t+2.
//  - Sustained throughput is one pulse per GAP cycles over all channels.
//  - Grant decision reads the registered counters, so a req in the decision cycle is counted but not yet eligible.
//  o_ch changes only in ISSUE cycles and is never X after reset.
// CONFIGURATION
//  PSYNC_SCHED_PRIO_EN defined:
//  - Channel 0 has fixed top priority: it is granted whenever its counter is nonzero at a decision point.
//  - Channels 1..N_CH-1 share round-robin among themselves; ptr is not advanced by channel-0 grants.
//  Not defined: pure round-robin over all N_CH channels.
// STRUCTURE
//  Package psync_sched_pkg:
//  - state_t enum {IDLE, ISSUE, HOLD};
//  - function ch_w(n) = $clog2(n);
//  - GAP_W localparam helper.
//  Sub-module psync_rr_arb: combinational first-set-at-or-after-pointer picker.
//  - Inputs: mask[N_CH], ptr. Outputs: gnt_valid, gnt_idx.
//  - Instantiated once; the PRIO_EN variant masks channel 0 out and muxes it in ahead of the picker.
// TESTING
//  - Reset: sys_rst_n=0 asynchronously mid-HOLD with pending=4'b0110 -> o=0, o_ch=0, pending=0, ovf=0 immediately; no pulses after release without req.
//  - Single event: req=4'b0100 at cycle t -> o=1, o_ch=2 at t+2; pending=0 from t+3; no further pulse.
//  - Round-robin, GAP=4: req=4'b1111 once -> pulses with o_ch=0,1,2,3 spaced exactly 4 cycles; total 4 pulses.
//  - Saturation, CNT_W=2: 5 req pulses on ch1 while ch0 is serviced -> ovf[1]=1, exactly 3 ch1 pulses issued; ovf_clr -> ovf=0.
//  - Simultaneous req and grant on ch3 with count=1 -> count stays 1, one additional pulse follows GAP cycles later.
//  - PSYNC_SCHED_PRIO_EN: ch0 requests continuously with ch1/ch2 pending -> every decision grants ch0; without the macro grants alternate 0,1,2,0.

Source files
------------

// File: rtl/psync_sched_pkg.sv
// rtl/psync_sched_pkg.sv - shared types and helpers for the psync scheduler
// Contents:
//   state_t  scheduler FSM states
//   ch_w     width of a channel index for n channels
//   GAP_W    width of the hold down-counter; GAP may be up to 2**GAP_W
package psync_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int GAP_W = 8;

endpackage

// File: rtl/psync_sched_if.sv
// rtl/psync_sched_if.sv - request/pulse bundle between event sources and the scheduler
// Signals:
//   req      per-channel event pulses
//   ovf_clr  one-cycle strobe clearing all ovf bits
//   o        one-cycle pulse toward the psync input
//   o_ch     channel of the last issued pulse
//   pending  bit k = channel k has queued events
//   ovf      sticky per-channel lost-event flags
// Modports: master = event-source side, slave = scheduler side.
interface psync_sched_if #(
    parameter int N_CH = 4
);
    localparam int W = psync_sched_pkg::ch_w(N_CH);

    logic [N_CH-1:0] req;
    logic            ovf_clr;
    logic            o;
    logic [W-1:0]    o_ch;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] ovf;

    modport master (
        output req, ovf_clr,
        input  o, o_ch, pending, ovf
    );

    modport slave (
        input  req, ovf_clr,
        output o, o_ch, pending, ovf
    );
endinterface

// File: rtl/psync_rr_arb.sv
// rtl/psync_rr_arb.sv - combinational first-set-at-or-after-pointer picker
// Ports:
//   mask       in  candidate channels
//   ptr        in  channel searched first; search wraps past N_CH-1 to 0
//   gnt_valid  out some mask bit is set
//   gnt_idx    out chosen channel (0 when gnt_valid=0)
module psync_rr_arb #(
    parameter int N_CH = 4,
    parameter int W    = 2
) (
    input  logic [N_CH-1:0] mask,
    input  logic [W-1:0]    ptr,
    output logic            gnt_valid,
    output logic [W-1:0]    gnt_idx
);

    int         j;
    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the closest set bit is the last written.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        idx       = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N_CH) begin
                j = j - N_CH;
            end
            idx = W'(j);
            if (mask[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/psync_sched.sv
// rtl/psync_sched.sv - round-robin pulse scheduler feeding one shared psync input
// Ports:
//   sys_clk    source-domain clock
//   sys_rst_n  asynchronous active-low reset
//   bus        psync_sched_if.slave: req/ovf_clr in; o/o_ch/pending/ovf out
// Parameters: N_CH channels, CNT_W pending-counter width, GAP min cycles between pulses (>=2).
// Build option PSYNC_SCHED_PRIO_EN: channel 0 always wins a decision when it has
// pending events; channels 1..N_CH-1 share round-robin among themselves.
module psync_sched
    import psync_sched_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 4
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    psync_sched_if.slave bus
);

    localparam int W = ch_w(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt [N_CH];
    logic [N_CH-1:0]    nz;
    logic [N_CH-1:0]    dec;
    logic [N_CH-1:0]    ovf_q;
    logic [W-1:0]       ptr;
    logic [W-1:0]       o_ch_q;
    logic [GAP_W-1:0]   hold_cnt;

    logic [N_CH-1:0]    arb_mask;
    logic               arb_valid;
    logic [W-1:0]       arb_idx;
    logic               sel_valid;
    logic [W-1:0]       sel_idx;
    logic               adv_ptr;
    logic               decide;
    logic               take;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            nz[k]  = (cnt[k] != '0);
            // The issued channel is consumed during its ISSUE cycle.
            dec[k] = (state == ISSUE) && (o_ch_q == W'(k));
        end
    end

`ifdef PSYNC_SCHED_PRIO_EN
    assign arb_mask  = nz & ~N_CH'(1);
    assign sel_valid = nz[0] | arb_valid;
    assign sel_idx   = nz[0] ? '0 : arb_idx;
    assign adv_ptr   = ~nz[0];
`else
    assign arb_mask  = nz;
    assign sel_valid = arb_valid;
    assign sel_idx   = arb_idx;
    assign adv_ptr   = 1'b1;
`endif

    psync_rr_arb #(
        .N_CH (N_CH),
        .W    (W)
    ) u_arb (
        .mask      (arb_mask),
        .ptr       (ptr),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    always_comb begin
        state_nxt = state;
        decide    = 1'b0;
        case (state)
            IDLE: begin
                decide = 1'b1;
                if (sel_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                // Decide in the last HOLD cycle so back-to-back pulses are exactly GAP apart.
                if (hold_cnt == '0) begin
                    decide    = 1'b1;
                    state_nxt = sel_valid ? ISSUE : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign take = decide & sel_valid;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            o_ch_q   <= '0;
            ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ISSUE) begin
                hold_cnt <= GAP_W'(GAP - 2);
            end else if ((state == HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - GAP_W'(1);
            end
            if (take) begin
                o_ch_q <= sel_idx;
                if (adv_ptr) begin
                    ptr <= (sel_idx == W'(N_CH - 1)) ? '0 : sel_idx + W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                cnt[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (bus.req[k] && !dec[k]) begin
                    if (cnt[k] != CNT_MAX) begin
                        cnt[k] <= cnt[k] + CNT_W'(1);
                    end
                end else if (!bus.req[k] && dec[k]) begin
                    cnt[k] <= cnt[k] - CNT_W'(1);
                end
                // A loss in the clear cycle must still be reported.
                if (bus.req[k] && !dec[k] && (cnt[k] == CNT_MAX)) begin
                    ovf_q[k] <= 1'b1;
                end else if (bus.ovf_clr) begin
                    ovf_q[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.o       = (state == ISSUE);
    assign bus.o_ch    = o_ch_q;
    assign bus.pending = nz;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_psync_sched.sv
// tb/tb_psync_sched.sv - self-checking bench for psync_sched (N_CH=4, CNT_W=2, GAP=4)
module tb_psync_sched;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    logic sys_clk;
    logic sys_rst_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t e;

    psync_sched_if #(.N_CH(4)) bus ();

    psync_sched #(
        .N_CH  (4),
        .CNT_W (2),
        .GAP   (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial cyc = 0;
    always @(posedge sys_clk) cyc = cyc + 1;

    // Scoreboard: every pulse must match the oldest expected (channel, cycle).
    always @(negedge sys_clk) begin
        if (bus.o === 1'b1) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL pulse_unexpected cyc=%0d o_ch=%0d", cyc, bus.o_ch);
            end else begin
                e = exp_q.pop_front();
                if (bus.o_ch !== 2'(e.ch) || cyc != e.cyc) begin
                    bad = bad + 1;
                    $display("FAIL pulse got ch=%0d cyc=%0d want ch=%0d cyc=%0d", bus.o_ch, cyc, e.ch, e.cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        int t;
        sys_rst_n   = 1'b0;
        bus.req     = '0;
        bus.ovf_clr = 1'b0;
        step(3);
        total++; if (bus.o !== 1'b0)       begin bad++; $display("FAIL rst_o got=%b want=0", bus.o); end
        total++; if (bus.o_ch !== 2'd0)    begin bad++; $display("FAIL rst_o_ch got=%0d want=0", bus.o_ch); end
        total++; if (bus.pending !== 4'b0) begin bad++; $display("FAIL rst_pending got=%b want=0000", bus.pending); end
        total++; if (bus.ovf !== 4'b0)     begin bad++; $display("FAIL rst_ovf got=%b want=0000", bus.ovf); end
        sys_rst_n = 1'b1;
        step(2);
        t = cyc;
        exp_q.push_back('{1, t + 2});
        bus.req = 4'b0110;
        step(1);
        bus.req = 4'b0010;
        step(1);
        bus.req = 4'b0000;
        step(1);
        total++; if (bus.pending !== 4'b0110) begin bad++; $display("FAIL hold_pending got=%b want=0110", bus.pending); end
        total++; if (bus.o_ch !== 2'd1)       begin bad++; $display("FAIL hold_o_ch got=%0d want=1", bus.o_ch); end
        step(1);
        #2 sys_rst_n = 1'b0;
        #1;
        total++; if (bus.o !== 1'b0)       begin bad++; $display("FAIL midrst_o got=%b want=0", bus.o); end
        total++; if (bus.o_ch !== 2'd0)    begin bad++; $display("FAIL midrst_o_ch got=%0d want=0", bus.o_ch); end
        total++; if (bus.pending !== 4'b0) begin bad++; $display("FAIL midrst_pending got=%b want=0000", bus.pending); end
        total++; if (bus.ovf !== 4'b0)     begin bad++; $display("FAIL midrst_ovf got=%b want=0000", bus.ovf); end
        step(1);
        sys_rst_n = 1'b1;
        step(20);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL reset_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        int t;
        t = cyc;
        exp_q.push_back('{0, t + 2});
        exp_q.push_back('{1, t + 6});
        exp_q.push_back('{2, t + 10});
        exp_q.push_back('{3, t + 14});
        bus.req = 4'b1111;
        step(1);
        bus.req = 4'b0000;
        total++; if (bus.pending !== 4'b1111) begin bad++; $display("FAIL rr_pending got=%b want=1111", bus.pending); end
        step(20);
        total++; if (bus.pending !== 4'b0) begin bad++; $display("FAIL rr_drained got=%b want=0000", bus.pending); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rr_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_single();
        int t;
        t = cyc;
        exp_q.push_back('{2, t + 2});
        bus.req = 4'b0100;
        step(1);
        bus.req = 4'b0000;
        total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL single_pend1 got=%b want=0100", bus.pending); end
        step(1);
        total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL single_pend2 got=%b want=0100", bus.pending); end
        step(1);
        total++; if (bus.pending !== 4'b0) begin bad++; $display("FAIL single_pend3 got=%b want=0000", bus.pending); end
        step(15);
        total++; if (bus.o_ch !== 2'd2) begin bad++; $display("FAIL single_o_ch got=%0d want=2", bus.o_ch); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_req_and_grant();
        int t;
        t = cyc;
        exp_q.push_back('{3, t + 2});
        exp_q.push_back('{3, t + 6});
        bus.req = 4'b1000;
        step(1);
        bus.req = 4'b0000;
        step(1);
        bus.req = 4'b1000;
        step(1);
        bus.req = 4'b0000;
        total++; if (bus.pending !== 4'b1000) begin bad++; $display("FAIL rg_pending got=%b want=1000", bus.pending); end
        step(4);
        total++; if (bus.pending !== 4'b0) begin bad++; $display("FAIL rg_drained got=%b want=0000", bus.pending); end
        step(12);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rg_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_saturation();
        int t;
        t = cyc;
        exp_q.push_back('{0, t + 2});
        exp_q.push_back('{1, t + 6});
        exp_q.push_back('{1, t + 10});
        exp_q.push_back('{1, t + 14});
        bus.req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step(1);
            bus.req = 4'b0010;
        end
        step(1);
        bus.req = 4'b0000;
        total++; if (bus.ovf !== 4'b0010) begin bad++; $display("FAIL sat_ovf got=%b want=0010", bus.ovf); end
        step(12);
        total++; if (bus.pending !== 4'b0) begin bad++; $display("FAIL sat_drained got=%b want=0000", bus.pending); end
        total++; if (bus.ovf !== 4'b0010) begin bad++; $display("FAIL sat_sticky got=%b want=0010", bus.ovf); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sat_missing got=%0d want=0", exp_q.size()); end
        bus.ovf_clr = 1'b1;
        step(1);
        bus.ovf_clr = 1'b0;
        total++; if (bus.ovf !== 4'b0) begin bad++; $display("FAIL sat_clr got=%b want=0000", bus.ovf); end
    endtask

    task automatic test_prio();
        int t;
        sys_rst_n = 1'b0;
        step(1);
        sys_rst_n = 1'b1;
        step(1);
        t = cyc;
`ifdef PSYNC_SCHED_PRIO_EN
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{0, t + 2 + 4 * i});
        end
        exp_q.push_back('{1, t + 26});
        exp_q.push_back('{2, t + 30});
`else
        exp_q.push_back('{0, t + 2});
        exp_q.push_back('{1, t + 6});
        exp_q.push_back('{2, t + 10});
        exp_q.push_back('{0, t + 14});
        exp_q.push_back('{0, t + 18});
        exp_q.push_back('{0, t + 22});
`endif
        bus.req = 4'b0111;
        for (int i = 0; i < 11; i++) begin
            step(1);
            bus.req = 4'b0001;
        end
        step(1);
        bus.req = 4'b0000;
        step(30);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL prio_missing got=%0d want=0", exp_q.size()); end
        total++; if (bus.ovf !== 4'b0001) begin bad++; $display("FAIL prio_ovf got=%b want=0001", bus.ovf); end
        total++; if (bus.pending !== 4'b0) begin bad++; $display("FAIL prio_drained got=%b want=0000", bus.pending); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_req_and_grant();
        test_saturation();
        test_prio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
